// File: rtl/fxp_divider.sv
// Signed fixed-point divider: restoring radix-2, saturating output.
// Ports: clk, rst (sync, active-high), start, a, b -> out, busy, done,
//        overflow, underflow, dbz. Macro FXP_DIV_ROUND_EN adds rounding.
module fxp_divider #(
    parameter int I1    = 3,
    parameter int F1    = 2,
    parameter int I2    = 4,
    parameter int F2    = 2,
    parameter int OUT_I = 5,
    parameter int OUT_F = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [I1+F1-1:0]       a,
    input  logic [I2+F2-1:0]       b,
    output logic [OUT_I+OUT_F-1:0] out,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow,
    output logic                   underflow,
    output logic                   dbz
);

    localparam int WA = I1 + F1;
    localparam int WB = I2 + F2;
    localparam int W  = OUT_I + OUT_F;
    localparam int SH = OUT_F + F2 - F1;
`ifdef FXP_DIV_ROUND_EN
    localparam int RND = 1;
`else
    localparam int RND = 0;
`endif
    localparam int NI   = WA + SH + RND;
    localparam int CNTW = $clog2(NI + 1);
    localparam int CW   = ((NI > W) ? NI : W) + 1;

    localparam logic [W-1:0]  OUT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]  OUT_MIN = {1'b1, {(W-1){1'b0}}};
    localparam logic [CW-1:0] POS_LIM = (CW'(1) << (W - 1)) - CW'(1);
    localparam logic [CW-1:0] NEG_LIM = CW'(1) << (W - 1);

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIN} state_t;

    state_t          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [WB-1:0]   rem_q, rem_d;
    logic [WB-1:0]   divs_q, divs_d;
    logic [NI-1:0]   quo_q, quo_d;
    logic            sign_q, sign_d;
    logic            zero_q, zero_d;
    logic            pend_q, pend_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [W-1:0]    out_q, out_d;
    logic            ovf_q, ovf_d;
    logic            udf_q, udf_d;
    logic            dbz_q, dbz_d;

    logic [WA-1:0]   abs_a;
    logic [WB-1:0]   abs_b;
    logic [WB:0]     rem_sh;
    logic [WB:0]     diff;
    logic            take;
    logic [CW-1:0]   mag;

    always_comb begin
        abs_a  = a[WA-1] ? -a : a;
        abs_b  = b[WB-1] ? -b : b;
        // Quotient register doubles as the dividend shifter.
        rem_sh = {rem_q, quo_q[NI-1]};
        diff   = rem_sh - {1'b0, divs_q};
        take   = (rem_sh >= {1'b0, divs_q});
`ifdef FXP_DIV_ROUND_EN
        // Extra LSB is the half bit: round half away from zero.
        mag    = CW'(quo_q[NI-1:1]) + CW'(quo_q[0]);
`else
        mag    = CW'(quo_q);
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        divs_d  = divs_q;
        quo_d   = quo_q;
        sign_d  = sign_q;
        zero_d  = zero_q;
        pend_d  = pend_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        out_d   = out_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            S_IDLE: begin
                if (pend_q) begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                    pend_d = 1'b0;
                end else if (start) begin
                    busy_d = 1'b1;
                    sign_d = a[WA-1] ^ b[WB-1];
                    divs_d = abs_b;
                    quo_d  = NI'(abs_a) << (SH + RND);
                    rem_d  = '0;
                    cnt_d  = '0;
                    zero_d = (b == '0);
                    state_d = (b == '0) ? S_FIN : S_DIV;
                end
            end
            S_DIV: begin
                rem_d = take ? diff[WB-1:0] : rem_sh[WB-1:0];
                quo_d = {quo_q[NI-2:0], take};
                cnt_d = cnt_q + CNTW'(1);
                if (cnt_q == CNTW'(NI - 1)) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                pend_d  = 1'b1;
                ovf_d   = 1'b0;
                udf_d   = 1'b0;
                dbz_d   = zero_q;
                if (zero_q) begin
                    out_d = sign_q ? OUT_MIN : OUT_MAX;
                    udf_d = sign_q;
                    ovf_d = !sign_q;
                end else if (!sign_q) begin
                    if (mag > POS_LIM) begin
                        out_d = OUT_MAX;
                        ovf_d = 1'b1;
                    end else begin
                        out_d = mag[W-1:0];
                    end
                end else begin
                    if (mag > NEG_LIM) begin
                        out_d = OUT_MIN;
                        udf_d = 1'b1;
                    end else begin
                        out_d = -mag[W-1:0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            divs_q  <= '0;
            quo_q   <= '0;
            sign_q  <= 1'b0;
            zero_q  <= 1'b0;
            pend_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            divs_q  <= divs_d;
            quo_q   <= quo_d;
            sign_q  <= sign_d;
            zero_q  <= zero_d;
            pend_q  <= pend_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            out_q   <= out_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            dbz_q   <= dbz_d;
        end
    end

    assign out       = out_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign overflow  = ovf_q;
    assign underflow = udf_q;
    assign dbz       = dbz_q;

endmodule

// File: tb/tb_fxp_divider.sv
// Directed-vector bench for fxp_divider (default parameters).
// Expected quotients hand-computed for Q3.2 / Q4.2 -> Q5.3.
module tb_fxp_divider;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [4:0] a;
    logic [5:0] b;
    logic [7:0] out;
    logic       busy, done, overflow, underflow, dbz;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef FXP_DIV_ROUND_EN
    localparam int LAT = 11;
    localparam logic [7:0] Q_1_3  = 8'h03;
    localparam logic [7:0] Q_M1_3 = 8'hFD;
`else
    localparam int LAT = 10;
    localparam logic [7:0] Q_1_3  = 8'h02;
    localparam logic [7:0] Q_M1_3 = 8'hFE;
`endif

    always #5 clk = ~clk;

    fxp_divider dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .out(out), .busy(busy), .done(done), .overflow(overflow),
        .underflow(underflow), .dbz(dbz)
    );

    typedef struct {
        logic [4:0] a;
        logic [5:0] b;
        logic [7:0] q;
        logic       ovf;
        logic       udf;
        logic       dz;
        int         lat;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Accepts at the next rising edge; returns edges until done is seen.
    task automatic run(input logic [4:0] av, input logic [5:0] bv,
                       output int lat);
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = ~av; b = ~bv;
        chk("busy_after_accept", int'(busy), 1);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    vec_t vt[$];

    initial begin
        int lat;
        int ndone;

        vt.push_back('{5'b00110, 6'b000010, 8'h18, 0, 0, 0, LAT});
        vt.push_back('{5'b11000, 6'b000001, 8'hC0, 0, 0, 0, LAT});
        vt.push_back('{5'b10000, 6'b000001, 8'h80, 0, 0, 0, LAT});
        vt.push_back('{5'b10000, 6'b111111, 8'h7F, 1, 0, 0, LAT});
        vt.push_back('{5'b11100, 6'b000000, 8'h80, 0, 1, 1, 2});
        vt.push_back('{5'b00100, 6'b000000, 8'h7F, 1, 0, 1, 2});
        vt.push_back('{5'b00100, 6'b001100, Q_1_3, 0, 0, 0, LAT});
        vt.push_back('{5'b11100, 6'b001100, Q_M1_3, 0, 0, 0, LAT});
        vt.push_back('{5'b00000, 6'b111111, 8'h00, 0, 0, 0, LAT});
        vt.push_back('{5'b00001, 6'b100000, 8'h00, 0, 0, 0, LAT});
        vt.push_back('{5'b01111, 6'b111111, 8'h88, 0, 0, 0, LAT});
        vt.push_back('{5'b00011, 6'b000011, 8'h08, 0, 0, 0, LAT});
        vt.push_back('{5'b01000, 6'b000001, 8'h40, 0, 0, 0, LAT});

        rst = 1'b1; start = 1'b1; a = 5'b00110; b = 6'b000010;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0;
        chk("rst_out", int'(out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_udf", int'(underflow), 0);
        chk("rst_dbz", int'(dbz), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("start_in_rst_ignored", int'(busy), 0);

        foreach (vt[i]) begin
            run(vt[i].a, vt[i].b, lat);
            chk($sformatf("v%0d_lat", i), lat, vt[i].lat);
            chk($sformatf("v%0d_out", i), int'(out), int'(vt[i].q));
            chk($sformatf("v%0d_ovf", i), int'(overflow), int'(vt[i].ovf));
            chk($sformatf("v%0d_udf", i), int'(underflow), int'(vt[i].udf));
            chk($sformatf("v%0d_dbz", i), int'(dbz), int'(vt[i].dz));
            chk($sformatf("v%0d_busy", i), int'(busy), 0);
            @(posedge clk); #1;
            chk($sformatf("v%0d_pulse", i), int'(done), 0);
            chk($sformatf("v%0d_hold", i), int'(out), int'(vt[i].q));
        end

        // Second start while busy must be dropped.
        @(negedge clk);
        a = 5'b00110; b = 6'b000010; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        a = 5'b10000; b = 6'b111111; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("busy_single_done", ndone, 1);
        chk("busy_out", int'(out), 8'h18);
        chk("busy_ovf", int'(overflow), 0);
        chk("busy_idle", int'(busy), 0);

        // Reset in the middle of a division.
        @(negedge clk);
        a = 5'b11000; b = 6'b000001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_out", int'(out), 0);
        chk("mid_rst_busy", int'(busy), 0);
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("mid_rst_no_done", ndone, 0);
        chk("mid_rst_out_hold", int'(out), 0);

        run(5'b11000, 6'b000001, lat);
        chk("post_rst_lat", lat, LAT);
        chk("post_rst_out", int'(out), 8'hC0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
